// File: rtl/tlul_pkg.sv
// TL-UL type and opcode definitions shared by the register adapter and its bench.
package tlul_pkg;

    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] ACCESS_ACK       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_reg_adapter.sv
// Bridges a single outstanding TL-UL request onto a strobe/ack register port,
// with request decode checks and an ACCESS-phase timeout.
module tlul_reg_adapter
    import tlul_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  tl_h2d_t     tl_i,
    output tl_d2h_t     tl_o,
    output logic        reg_re_o,
    output logic        reg_we_o,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic [3:0]  reg_be_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_ack_i,
    input  logic        reg_err_i,
    output logic        timeout_err_o
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic        r_is_read;
    logic        r_re;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_d_valid;
    logic [2:0]  r_d_opcode;
    logic [1:0]  r_d_size;
    logic [7:0]  r_d_source;
    logic [31:0] r_d_data;
    logic        r_d_error;

    logic w_size_err;
    logic w_align_err;
    logic w_op_err;
    logic w_mask_err;
    logic w_dec_err;
    logic w_is_get;
    logic w_last;
    logic w_unused;

    assign w_is_get    = (tl_i.a_opcode == GET);
    assign w_size_err  = (tl_i.a_size > 2'd2);
    assign w_align_err = ((tl_i.a_size == 2'd1) && tl_i.a_address[0])
                      || ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00));
    assign w_op_err    = !(w_is_get || (tl_i.a_opcode == PUT_FULL_DATA)
                                    || (tl_i.a_opcode == PUT_PARTIAL_DATA));
    assign w_mask_err  = (tl_i.a_opcode == PUT_FULL_DATA) && (tl_i.a_size == 2'd2)
                      && (tl_i.a_mask != 4'hF);
    assign w_dec_err   = w_size_err || w_align_err || w_op_err || w_mask_err;
    assign w_last      = (r_cnt == LP_LAST);
    assign w_unused    = ^tl_i.a_param;

    // NOTE: every state bit, capture register included, is a flop written with <=
    // and cleared by the synchronous reset, so an aborted access leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_read  <= 1'b0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else begin
            r_re <= 1'b0;
            r_we <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (tl_i.a_valid) begin
                        r_is_read  <= w_is_get;
                        r_d_opcode <= w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
                        r_d_size   <= tl_i.a_size;
                        r_d_source <= tl_i.a_source;
                        r_d_data   <= '0;
                        r_cnt      <= '0;
                        if (w_dec_err) begin
                            r_state   <= RESP;
                            r_d_valid <= 1'b1;
                            r_d_error <= 1'b1;
                        end else begin
                            r_state   <= ACCESS;
                            r_d_error <= 1'b0;
                            r_addr    <= {tl_i.a_address[31:2], 2'b00};
                            r_wdata   <= tl_i.a_data;
                            r_be      <= tl_i.a_mask;
                            r_re      <= w_is_get;
                            r_we      <= !w_is_get;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final counted cycle still wins over the timeout.
                    if (reg_ack_i) begin
                        r_state   <= RESP;
                        r_d_valid <= 1'b1;
                        r_d_data  <= r_is_read ? reg_rdata_i : 32'h0;
                        r_d_error <= reg_err_i;
                    end else if (w_last) begin
                        r_state   <= RESP;
                        r_d_valid <= 1'b1;
                        r_d_data  <= '0;
                        r_d_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (tl_i.d_ready) begin
                        r_state   <= IDLE;
                        r_d_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The pulse must land in the expiring ACCESS cycle itself, so it depends on the live ack.
    assign timeout_err_o = (r_state == ACCESS) && w_last && !reg_ack_i && !rst_i;

    assign reg_re_o    = r_re;
    assign reg_we_o    = r_we;
    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_be_o    = r_be;

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = (r_state == IDLE);
        tl_o.d_valid  = r_d_valid;
        tl_o.d_opcode = r_d_opcode;
        tl_o.d_size   = r_d_size;
        tl_o.d_source = r_d_source;
        tl_o.d_data   = r_d_data;
        tl_o.d_error  = r_d_error;
    end

endmodule

// File: tb/tb_tlul_reg_adapter.sv
// Directed bench for tlul_reg_adapter: expected D responses are queued when a
// request is driven and compared when d_valid appears.
module tb_tlul_reg_adapter;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        reg_re;
    logic        reg_we;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        reg_err;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int to_cnt = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [1:0]  size;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    tlul_reg_adapter #(.TIMEOUT(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_i         (tl_i),
        .tl_o         (tl_o),
        .reg_re_o     (reg_re),
        .reg_we_o     (reg_we),
        .reg_addr_o   (reg_addr),
        .reg_wdata_o  (reg_wdata),
        .reg_be_o     (reg_be),
        .reg_rdata_i  (reg_rdata),
        .reg_ack_i    (reg_ack),
        .reg_err_i    (reg_err),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_we)      we_cnt <= we_cnt + 1;
        if (reg_re)      re_cnt <= re_cnt + 1;
        if (timeout_err) to_cnt <= to_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] src, input logic [1:0] size,
                        input logic [31:0] data, input logic err);
        exp_t e;
        e.op = op; e.src = src; e.size = size; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    // Returns at the negedge of the cycle right after the A handshake.
    task automatic send_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src);
        int n = 0;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = mask;
        tl_i.a_size    = size;
        tl_i.a_source  = src;
        while (!tl_o.a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a_ready_wait", tl_o.a_ready, 1);
        @(negedge clk);
        tl_i.a_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int   n = 0;
        exp_t e;
        while (!tl_o.d_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_dvalid"}, tl_o.d_valid, 1);
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (tl_o.d_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_opcode"}, tl_o.d_opcode, e.op);
            check({tag, "_source"}, tl_o.d_source, e.src);
            check({tag, "_size"},   tl_o.d_size, e.size);
            check({tag, "_data"},   tl_o.d_data, e.data);
            check({tag, "_error"},  tl_o.d_error, e.err);
            check({tag, "_aready_during_d"}, tl_o.a_ready, 0);
            tl_i.d_ready = 1'b1;
            @(negedge clk);
            tl_i.d_ready = 1'b0;
            check({tag, "_dvalid_drop"}, tl_o.d_valid, 0);
            check({tag, "_aready_back"}, tl_o.a_ready, 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tl_d2h_t t;
        t = tl_o;
        t.a_ready = 1'b0;
        check({tag, "_tl_o_d"}, t, 0);
        check({tag, "_re"},     reg_re, 0);
        check({tag, "_we"},     reg_we, 0);
        check({tag, "_addr"},   reg_addr, 0);
        check({tag, "_wdata"},  reg_wdata, 0);
        check({tag, "_be"},     reg_be, 0);
        check({tag, "_timeout"}, timeout_err, 0);
    endtask

    initial begin
        int      w0;
        int      r0;
        int      t0;
        int      first_k;
        tl_d2h_t hold;

        rst       = 1'b1;
        tl_i      = '0;
        reg_rdata = '0;
        reg_ack   = 1'b0;
        reg_err   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        check("por_aready", tl_o.a_ready, 1);

        // Full-word write, ack one cycle after the strobe.
        w0 = we_cnt; r0 = re_cnt;
        push(ACCESS_ACK, 8'd3, 2'd2, 32'h0, 1'b0);
        send_a(PUT_FULL_DATA, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF, 2'd2, 8'd3);
        check("wr_we",    reg_we, 1);
        check("wr_re",    reg_re, 0);
        check("wr_be",    reg_be, 4'hF);
        check("wr_addr",  reg_addr, 32'h4000_0000);
        check("wr_wdata", reg_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        reg_ack = 1'b1;
        check("wr_we_once", reg_we, 0);
        check("wr_addr_hold", reg_addr, 32'h4000_0000);
        @(negedge clk);
        reg_ack = 1'b0;
        wait_resp("wr");
        check("wr_we_count", we_cnt - w0, 1);
        check("wr_re_count", re_cnt - r0, 0);

        // Read acked on the strobe cycle: d_valid at handshake+2.
        push(ACCESS_ACK_DATA, 8'd5, 2'd2, 32'h1234_5678, 1'b0);
        send_a(GET, 32'h4000_0004, 32'h0, 4'hF, 2'd2, 8'd5);
        check("rd_re", reg_re, 1);
        check("rd_addr", reg_addr, 32'h4000_0004);
        reg_ack   = 1'b1;
        reg_rdata = 32'h1234_5678;
        @(negedge clk);
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        check("rd_latency", tl_o.d_valid, 1);
        wait_resp("rd");

        // Decode errors: misaligned, bad opcode, short full-put mask, oversize.
        w0 = we_cnt; r0 = re_cnt;
        push(ACCESS_ACK_DATA, 8'd1, 2'd2, 32'h0, 1'b1);
        send_a(GET, 32'h4000_0002, 32'h0, 4'hF, 2'd2, 8'd1);
        check("dec_no_re", reg_re, 0);
        check("dec_fast_resp", tl_o.d_valid, 1);
        wait_resp("dec_align");
        push(ACCESS_ACK, 8'd2, 2'd2, 32'h0, 1'b1);
        send_a(3'd3, 32'h4000_0000, 32'h5555_5555, 4'hF, 2'd2, 8'd2);
        wait_resp("dec_op");
        push(ACCESS_ACK, 8'd4, 2'd2, 32'h0, 1'b1);
        send_a(PUT_FULL_DATA, 32'h4000_0008, 32'h1111_1111, 4'h7, 2'd2, 8'd4);
        wait_resp("dec_mask");
        push(ACCESS_ACK_DATA, 8'd6, 2'd3, 32'h0, 1'b1);
        send_a(GET, 32'h4000_0000, 32'h0, 4'hF, 2'd3, 8'd6);
        wait_resp("dec_size");
        check("dec_we_count", we_cnt - w0, 0);
        check("dec_re_count", re_cnt - r0, 0);

        // Partial write answered with a register-side error.
        push(ACCESS_ACK, 8'd7, 2'd2, 32'h0, 1'b1);
        send_a(PUT_PARTIAL_DATA, 32'h4000_000C, 32'hCAFE_0000, 4'hC, 2'd2, 8'd7);
        check("perr_be", reg_be, 4'hC);
        reg_ack = 1'b1;
        reg_err = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        reg_err = 1'b0;
        wait_resp("regerr");

        // Timeout: pulse in the 16th ACCESS cycle, then a late ack is ignored.
        t0 = to_cnt; w0 = we_cnt; r0 = re_cnt;
        first_k = 0;
        push(ACCESS_ACK_DATA, 8'd9, 2'd2, 32'h0, 1'b1);
        send_a(GET, 32'h4000_0010, 32'h0, 4'hF, 2'd2, 8'd9);
        for (int k = 1; k <= 16; k++) begin
            if (timeout_err && first_k == 0) first_k = k;
            @(negedge clk);
        end
        check("to_cycle", first_k, 16);
        check("to_pulses", to_cnt - t0, 1);
        check("to_resp", tl_o.d_valid, 1);
        reg_ack   = 1'b1;
        reg_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("to_late_ack_data", tl_o.d_data, 0);
        wait_resp("to");
        @(negedge clk);
        check("to_late_ack_idle", tl_o.d_valid, 0);
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        @(negedge clk);
        check("to_late_no_strobe", (we_cnt - w0) + (re_cnt - r0), 1);

        // Ack in the final counted cycle beats the timeout.
        t0 = to_cnt;
        push(ACCESS_ACK_DATA, 8'd10, 2'd2, 32'hA5A5_A5A5, 1'b0);
        send_a(GET, 32'h4000_0014, 32'h0, 4'hF, 2'd2, 8'd10);
        repeat (15) @(negedge clk);
        reg_ack   = 1'b1;
        reg_rdata = 32'hA5A5_A5A5;
        #1;
        check("tie_no_pulse", timeout_err, 0);
        @(negedge clk);
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        wait_resp("tie");
        check("tie_pulses", to_cnt - t0, 0);

        // Backpressure: D fields frozen and a_ready low for 10 cycles.
        push(ACCESS_ACK, 8'd11, 2'd2, 32'h0, 1'b0);
        send_a(PUT_FULL_DATA, 32'h4000_0018, 32'h0000_0012, 4'hF, 2'd2, 8'd11);
        reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        hold          = '0;
        hold.d_valid  = 1'b1;
        hold.d_opcode = ACCESS_ACK;
        hold.d_size   = 2'd2;
        hold.d_source = 8'd11;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", tl_o, hold);
            @(negedge clk);
        end
        wait_resp("bp");

        // Reset mid-ACCESS: silent abandon, late ack ignored, next write fine.
        r0 = re_cnt;
        send_a(GET, 32'h4000_0020, 32'h0, 4'hF, 2'd2, 8'd12);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst       = 1'b0;
        reg_ack   = 1'b1;
        reg_rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_d", tl_o.d_valid, 0);
            @(negedge clk);
        end
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        check("mid_rst_aready", tl_o.a_ready, 1);
        check("mid_rst_re_count", re_cnt - r0, 1);
        push(ACCESS_ACK, 8'd13, 2'd2, 32'h0, 1'b0);
        send_a(PUT_FULL_DATA, 32'h4000_0024, 32'h0000_0077, 4'hF, 2'd2, 8'd13);
        check("post_rst_we", reg_we, 1);
        check("post_rst_wdata", reg_wdata, 32'h0000_0077);
        reg_ack = 1'b1;
        @(negedge clk);
        reg_ack = 1'b0;
        wait_resp("post_rst");

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
